// File: rtl/gray_step_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gray_step_seq
// Reflected Gray-code step sequencer: free-running with a programmable dwell
// or single-stepped, up/down, synchronous load, wrap or halt at the end.
// Revision: 1.0
// ============================================================================
module gray_step_seq #(
    parameter int WIDTH = 3,
    parameter int DWELL = 10,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] flip,
    output logic             tick,
    output logic             tc,
    output logic             done
);
    localparam int                 c_CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_step_d;

    logic               w_halted;
    logic               w_step_edge;
    logic               w_dwell_end;
    logic               w_advance;
    logic               w_block;
    logic [WIDTH-1:0]   w_next_bin;
    logic [WIDTH-1:0]   w_next_gray;
    logic [WIDTH-1:0]   w_load_gray;

    assign w_halted    = (r_state == S_HALT);
    assign w_step_edge = step & ~r_step_d;
    assign w_dwell_end = (r_cnt == c_CNT_LAST);
    // Run mode paces advances by the dwell counter; idle mode by step edges.
    assign w_advance   = ~w_halted & (en ? w_dwell_end : w_step_edge);
    assign tc          = up ? (&bin) : ~(|bin);
    assign w_block     = (WRAP == 0) && tc;
    assign w_next_bin  = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);
    assign w_load_gray = load_bin ^ (load_bin >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_step_d <= 1'b0;
            gray     <= '0;
            bin      <= '0;
            flip     <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_step_d <= step;
            tick     <= 1'b0;
            flip     <= '0;
            if (load) begin
                bin     <= load_bin;
                gray    <= w_load_gray;
                r_cnt   <= '0;
                done    <= 1'b0;
                r_state <= en ? S_RUN : S_IDLE;
            end else begin
                if (w_halted || !en || w_dwell_end) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                if (w_advance && w_block) begin
                    // Attempted advance past the terminal code without wrap.
                    done    <= 1'b1;
                    r_state <= S_HALT;
                end else begin
                    if (w_advance) begin
                        bin  <= w_next_bin;
                        gray <= w_next_gray;
                        flip <= gray ^ w_next_gray;
                        tick <= 1'b1;
                    end
                    if (!w_halted) begin
                        r_state <= en ? S_RUN : S_IDLE;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire
